// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, operand-A source encodings, FSM states.
// The MUL state exists only when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_CLEAR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1
`ifdef SEQ_ALU_MUL_EN
        ,
        ST_MUL  = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// WIDTH-step shift-add multiplier. Operands load on start; one partial product per cycle.
// done is high in the cycle whose closing edge completes the last step; product is valid then.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               running_q, running_d;

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        if (start) begin
            mcand_d   = {{WIDTH{1'b0}}, a};
            mplier_d  = b;
            acc_d     = '0;
            cnt_d     = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                running_d = 1'b0;
            end
        end
    end

    // The final step's sum is handed out combinationally so the caller can
    // register it on the same edge that finishes the multiply.
    assign done    = running_q && (cnt_q == CW'(WIDTH - 1));
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential accumulator ALU with start/busy/done handshake and registered flags.
// Define SEQ_ALU_MUL_EN to build the multi-cycle multiplier; otherwise op 9 is illegal.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [OPW-1:0]   op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_sel;
    logic             sel_ok;
    logic             op_ok;
    logic [3:0]       op_lo;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [SHW-1:0]   sh;

    always_comb begin
        sel_ok = 1'b1;
        a_sel  = '0;
        case (in_sel)
            SEL_PERSIST: a_sel = out_q;
            SEL_LOAD:    a_sel = num1;
            SEL_CLEAR:   a_sel = '0;
            default:     sel_ok = 1'b0;
        endcase
        op_lo = 4'(op);
`ifdef SEQ_ALU_MUL_EN
        op_ok = (int'(op) <= int'(OP_MUL));
`else
        op_ok = (int'(op) <= int'(OP_SHR));
`endif
    end

    assign sh = b_q[SHW-1:0];

    always_comb begin
        alu_res = a_q;
        alu_c   = 1'b0;
        case (op_q)
            OP_PASS: alu_res = a_q;
            OP_ADD:  {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            // One guard bit past the data catches the last bit shifted out.
            OP_SHL:  {alu_c, alu_res} = {1'b0, a_q} << sh;
            OP_SHR:  {alu_res, alu_c} = {a_q, 1'b0} >> sh;
            default: alu_res = a_q;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic                 mul_go;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    assign mul_go = start && (state_q == ST_IDLE) && sel_ok && op_ok && (op_lo == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_go),
        .a       (a_sel),
        .b       (num2),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        out_d     = out_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a_sel;
                    b_d       = num2;
                    op_d      = op_lo;
                    illegal_d = !(sel_ok && op_ok);
                    state_d   = ST_EXEC;
`ifdef SEQ_ALU_MUL_EN
                    if (mul_go) begin
                        state_d = ST_MUL;
                    end
`endif
                end
            end
            ST_EXEC: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (illegal_q) begin
                    carry_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    out_d   = alu_res;
                    carry_d = alu_c;
                    zero_d  = (alu_res == '0);
                    err_d   = 1'b0;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    out_d   = mul_product[WIDTH-1:0];
                    carry_d = |mul_product[2*WIDTH-1:WIDTH];
                    zero_d  = (mul_product[WIDTH-1:0] == '0);
                    err_d   = 1'b0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            out_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH = 8); MUL scenarios follow SEQ_ALU_MUL_EN.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [3:0] op;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       carry;
    logic       zero;
    logic       err;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(8), .OPW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .op        (op),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] o);
        in_sel = s;
        num1   = a;
        num2   = b;
        op     = o;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Latency in cycles after the accepting edge; -1 when done never appears.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_sel = 3'b010; num1 = 8'h00; num2 = 8'h00; op = 4'd0;
        tick();
        tick();
        checks++; if (out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int lat;
        issue(3'b010, 8'h57, 8'h1A, 4'd1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_early_done got=%b exp=0", done); end
        num1 = 8'hFF; num2 = 8'hFF;
        wait_done(lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (out !== 8'h71) begin failures++; $display("FAIL add_out got=%h exp=71", out); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL add_carry got=%b exp=0", carry); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL add_done_width done=%b busy=%b exp=0,0", done, busy);
        end
    endtask

    task automatic test_sub_chain();
        int lat;
        issue(3'b010, 8'h1A, 8'h57, 4'd2);
        wait_done(lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL sub_latency got=%0d exp=1", lat); end
        checks++; if (out !== 8'hC3) begin failures++; $display("FAIL sub_out got=%h exp=c3", out); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL sub_borrow got=%b exp=1", carry); end
        issue(3'b100, 8'h99, 8'h3D, 4'd1);
        wait_done(lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL chain_latency got=%0d exp=1", lat); end
        checks++; if (out !== 8'h00) begin failures++; $display("FAIL chain_out got=%h exp=00", out); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL chain_carry got=%b exp=1", carry); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL chain_zero got=%b exp=1", zero); end
    endtask

    task automatic test_logic();
        int lat;
        logic [2:0] s_t [0:6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b100};
        logic [7:0] a_t [0:6] = '{8'hF0, 8'hF0, 8'hAA, 8'h0F, 8'h5A, 8'h77, 8'h66};
        logic [7:0] b_t [0:6] = '{8'h3C, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h12, 8'h81};
        logic [3:0] o_t [0:6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd0, 4'd4};
        logic [7:0] e_t [0:6] = '{8'h30, 8'hFF, 8'h55, 8'hF0, 8'h5A, 8'h00, 8'h81};
        for (int i = 0; i < 7; i++) begin
            issue(s_t[i], a_t[i], b_t[i], o_t[i]);
            wait_done(lat);
            checks++; if (lat != 1 || out !== e_t[i] || carry !== 1'b0 || zero !== (e_t[i] == 8'h00)) begin
                failures++;
                $display("FAIL logic_%0d lat=%0d out=%h carry=%b zero=%b exp lat=1 out=%h carry=0 zero=%b",
                         i, lat, out, carry, zero, e_t[i], (e_t[i] == 8'h00));
            end
        end
    endtask

    task automatic test_shift();
        int lat;
        logic [7:0] a_t [0:5] = '{8'h81, 8'h81, 8'h81, 8'h18, 8'h0F, 8'h80};
        logic [7:0] b_t [0:5] = '{8'h01, 8'h01, 8'h00, 8'h04, 8'h09, 8'h07};
        logic [3:0] o_t [0:5] = '{4'd7, 4'd8, 4'd7, 4'd8, 4'd7, 4'd8};
        logic [7:0] e_t [0:5] = '{8'h02, 8'h40, 8'h81, 8'h01, 8'h1E, 8'h01};
        logic       c_t [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(3'b010, a_t[i], b_t[i], o_t[i]);
            wait_done(lat);
            checks++; if (lat != 1 || out !== e_t[i] || carry !== c_t[i]) begin
                failures++;
                $display("FAIL shift_%0d lat=%0d out=%h carry=%b exp lat=1 out=%h carry=%b",
                         i, lat, out, carry, e_t[i], c_t[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int lat;
        issue(3'b010, 8'h81, 8'h01, 4'd7);
        wait_done(lat);
        issue(3'b010, 8'h11, 8'h22, 4'hC);
        wait_done(lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL illop_latency got=%0d exp=1", lat); end
        checks++; if (out !== 8'h02) begin failures++; $display("FAIL illop_out got=%h exp=02", out); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL illop_carry got=%b exp=0", carry); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illop_err got=%b exp=1", err); end
        issue(3'b011, 8'h11, 8'h22, 4'd1);
        wait_done(lat);
        checks++; if (lat != 1 || out !== 8'h02 || err !== 1'b1) begin
            failures++; $display("FAIL illsel_011 lat=%0d out=%h err=%b exp 1 02 1", lat, out, err);
        end
        issue(3'b000, 8'h11, 8'h22, 4'd1);
        wait_done(lat);
        checks++; if (lat != 1 || out !== 8'h02 || err !== 1'b1) begin
            failures++; $display("FAIL illsel_000 lat=%0d out=%h err=%b exp 1 02 1", lat, out, err);
        end
        issue(3'b010, 8'h03, 8'h04, 4'd1);
        wait_done(lat);
        checks++; if (out !== 8'h07 || err !== 1'b0) begin
            failures++; $display("FAIL err_clear out=%h err=%b exp 07 0", out, err);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int t0;
        int t1;
        issue(3'b010, 8'h10, 8'h00, 4'd0);
        wait_done(lat);
        t0 = $time;
        issue(3'b100, 8'h00, 8'h10, 4'd1);
        wait_done(lat);
        issue(3'b100, 8'h00, 8'h10, 4'd1);
        wait_done(lat);
        t1 = $time;
        checks++; if (out !== 8'h30) begin failures++; $display("FAIL b2b_out got=%h exp=30", out); end
        checks++; if (t1 - t0 != 40) begin failures++; $display("FAIL b2b_spacing got=%0d exp=40", t1 - t0); end
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic test_mul();
        int bad = 0;
        int extra = 0;
        issue(3'b010, 8'h57, 8'h1A, 4'd9);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3 || i == 5) begin
                start = 1'b1; in_sel = 3'b010; op = 4'd1; num1 = 8'h01; num2 = 8'h01;
            end
            tick();
            start = 1'b0;
            if (i < 8 && (busy !== 1'b1 || done !== 1'b0)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=0", bad); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL mul_done_at_8 got=%b exp=1", done); end
        checks++; if (out !== 8'hD6) begin failures++; $display("FAIL mul_out got=%h exp=d6", out); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL mul_carry got=%b exp=1", carry); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra != 0 || out !== 8'hD6) begin
            failures++; $display("FAIL mul_no_queue extra=%0d out=%h exp 0 d6", extra, out);
        end
    endtask
`else
    task automatic test_mul_disabled();
        int lat;
        issue(3'b010, 8'h57, 8'h1A, 4'd9);
        wait_done(lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL mul_off_latency got=%0d exp=1", lat); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL mul_off_err got=%b exp=1", err); end
        checks++; if (out !== 8'h30) begin failures++; $display("FAIL mul_off_out got=%h exp=30", out); end
    endtask
`endif

    task automatic test_reset_mid();
        int extra = 0;
`ifdef SEQ_ALU_MUL_EN
        issue(3'b010, 8'h57, 8'h1A, 4'd9);
        tick();
        tick();
        tick();
`else
        issue(3'b010, 8'h03, 8'h04, 4'd1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out !== 8'h00 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid out=%h zero=%b busy=%b done=%b carry=%b exp 00 1 0 0 0",
                     out, zero, busy, done, carry);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", extra); end
        in_sel = 3'b010; num1 = 8'h55; num2 = 8'h00; op = 4'd0;
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_vs_start_busy got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0 || out !== 8'h00) begin
            failures++; $display("FAIL reset_vs_start_result done=%b out=%h exp 0 00", done, out);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_chain();
        test_logic();
        test_shift();
        test_illegal();
        test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
